// File: rtl/systolic_issue_seq.sv
// systolic_issue_seq
//   Converts one tile command into the lane-0 beat stream for the 8-lane
//   control skew chain. It issues one read beat per k-step, waits for the
//   chain and the SRAM read latency to flush, and then pulses done.
//
//   All outputs are registered. The FSM state selects what the next clock
//   edge registers onto the outputs, and hold is sampled on that same edge.
//   So a beat appears in the cycle after the edge that issued it. A hold
//   sampled on an edge suppresses the beat of the following cycle.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; outputs idle
//   ISSUE | emitting beats (one per edge with hold=0)
//   DRAIN | flushing LANES+RD_LAT cycles; hold ignored
//   DONE  | next edge registers done=1/busy=1, then IDLE
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe (accepted only in IDLE)
//   base_addr, stride address of beat 0 and per-beat increment
//   k_len             number of beats (0 = immediate completion)
//   hold              pauses issuing while high
//   en, cmen, rdaddr  lane-0 enable, last-beat marker, read address
//   busy, done        command in flight / one-cycle completion pulse
module systolic_issue_seq #(
    parameter int LANES  = 8,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  k_len,
    input  logic              hold,
    output logic              en,
    output logic              cmen,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_N = LANES + RD_LAT;
    localparam int CNT_W   = (DRAIN_N < 1) ? 1 : $clog2(DRAIN_N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_d, cmen_d, busy_d, done_d;
    logic [ADDR_W-1:0]  rdaddr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
            en       <= 1'b0;
            cmen     <= 1'b0;
            rdaddr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
            en       <= en_d;
            cmen     <= cmen_d;
            rdaddr   <= rdaddr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        en_d     = 1'b0;
        cmen_d   = 1'b0;
        rdaddr_d = rdaddr;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d    = k_len;
                        stride_d = stride;
                        addr_d   = base_addr;
                        idx_d    = '0;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                if (!hold) begin
                    en_d     = 1'b1;
                    rdaddr_d = addr_q;
                    addr_d   = addr_q + stride_q;   // wraps modulo 2^ADDR_W
                    idx_d    = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        cmen_d  = 1'b1;
                        cnt_d   = CNT_W'(DRAIN_N);
                        state_d = (DRAIN_N == 0) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_issue_seq.sv
// tb_systolic_issue_seq
//   Directed bench for systolic_issue_seq with default parameters
//   (LANES=8, RD_LAT=1, so a command of k beats completes in cycle k+10).
//   Inputs set before tick() are sampled on that tick's edge. The edge
//   that samples start is cycle 0, and outputs are read 1 ns after each
//   edge.
module tb_systolic_issue_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] k_len = '0;
    logic        hold = 1'b0;
    logic        en, cmen, busy, done;
    logic [31:0] rdaddr;

    int checks = 0;
    int errors = 0;

    systolic_issue_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .k_len     (k_len),
        .hold      (hold),
        .en        (en),
        .cmen      (cmen),
        .rdaddr    (rdaddr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0: present a command on the sampling edge.
    task automatic send_cmd(input logic [31:0] b, input logic [31:0] s, input logic [15:0] k);
        base_addr = b;
        stride    = s;
        k_len     = k;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({en, cmen, busy, done} !== 4'b0000 || rdaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset: en/cmen/busy/done=%b rdaddr=%h, required 0000 / 00000000",
                     {en, cmen, busy, done}, rdaddr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] exp;
        send_cmd(32'h100, 32'd4, 16'd4);
        for (int n = 1; n <= 15; n++) begin
            tick();
            exp = {n >= 1 && n <= 4, n == 4, n <= 14, n == 14};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL basic_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n <= 4) begin
                checks++;
                if (rdaddr !== 32'h100 + 32'(4 * (n - 1))) begin
                    errors++;
                    $display("FAIL basic_addr cycle %0d: rdaddr=%h, required %h",
                             n, rdaddr, 32'h100 + 32'(4 * (n - 1)));
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0]  exp;
        logic [31:0] exp_addr [1:6] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h108, 32'h10C};
        send_cmd(32'h100, 32'd4, 16'd4);
        for (int n = 1; n <= 17; n++) begin
            hold = (n == 2 || n == 3);
            tick();
            exp = {n == 1 || (n >= 4 && n <= 6), n == 6, n <= 16, n == 16};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL hold_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n <= 6) begin
                checks++;
                if (rdaddr !== exp_addr[n]) begin
                    errors++;
                    $display("FAIL hold_addr cycle %0d: rdaddr=%h, required %h",
                             n, rdaddr, exp_addr[n]);
                end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_k1();
        logic [3:0] exp;
        send_cmd(32'h55, 32'd7, 16'd1);
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp = {n == 1, n == 1, n <= 11, n == 11};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL k1_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n == 1) begin
                checks++;
                if (rdaddr !== 32'h55) begin
                    errors++;
                    $display("FAIL k1_addr: rdaddr=%h, required 00000055", rdaddr);
                end
            end
        end
    endtask

    task automatic test_k0();
        logic [3:0] exp;
        send_cmd(32'h77, 32'd1, 16'd0);
        for (int n = 1; n <= 3; n++) begin
            tick();
            exp = {1'b0, 1'b0, n == 1, n == 1};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL k0_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
        end
    endtask

    // Stray starts in cycle 2 and in the done cycle (13) are ignored.
    // The start in cycle 14 begins a second one-beat command, which is done in cycle 25.
    task automatic test_wrap_ignored_start();
        logic [3:0]  exp;
        logic [31:0] exp_addr [1:3] = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
        send_cmd(32'hFFFF_FFF8, 32'd8, 16'd3);
        for (int n = 1; n <= 26; n++) begin
            start = (n == 2 || n == 13 || n == 14);
            if (n == 13) begin
                base_addr = 32'h200;
                stride    = 32'd1;
                k_len     = 16'd1;
            end
            tick();
            exp = {(n >= 1 && n <= 3) || n == 15, n == 3 || n == 15,
                   n <= 13 || (n >= 15 && n <= 25), n == 13 || n == 25};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL wrap_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n <= 3) begin
                checks++;
                if (rdaddr !== exp_addr[n]) begin
                    errors++;
                    $display("FAIL wrap_addr cycle %0d: rdaddr=%h, required %h",
                             n, rdaddr, exp_addr[n]);
                end
            end
            if (n == 15) begin
                checks++;
                if (rdaddr !== 32'h200) begin
                    errors++;
                    $display("FAIL restart_addr: rdaddr=%h, required 00000200", rdaddr);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        send_cmd(32'h0, 32'd1, 16'd8);
        for (int n = 1; n <= 20; n++) begin
            rst = (n == 3);
            tick();
            if (n <= 2 || n >= 4) begin
                exp = {n <= 2, 1'b0, n <= 2, 1'b0};
                checks++;
                if ({en, cmen, busy, done} !== exp) begin
                    errors++;
                    $display("FAIL rstmid_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                             n, {en, cmen, busy, done}, exp);
                end
            end
            if (n >= 4) begin
                checks++;
                if (rdaddr !== 32'h0) begin
                    errors++;
                    $display("FAIL rstmid_addr cycle %0d: rdaddr=%h, required 00000000", n, rdaddr);
                end
            end
        end
        rst = 1'b0;
        send_cmd(32'h40, 32'h10, 16'd2);
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp = {n <= 2, n == 2, n <= 12, n == 12};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL rstmid_restart cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n <= 2) begin
                checks++;
                if (rdaddr !== 32'h40 + 32'(16 * (n - 1))) begin
                    errors++;
                    $display("FAIL rstmid_restart_addr cycle %0d: rdaddr=%h, required %h",
                             n, rdaddr, 32'h40 + 32'(16 * (n - 1)));
                end
            end
        end
    endtask

    // Drain must ignore hold. stride=0 repeats the base address.
    task automatic test_hold_drain();
        logic [3:0] exp;
        send_cmd(32'h300, 32'd0, 16'd2);
        for (int n = 1; n <= 13; n++) begin
            hold = (n >= 3);
            tick();
            exp = {n <= 2, n == 2, n <= 12, n == 12};
            checks++;
            if ({en, cmen, busy, done} !== exp) begin
                errors++;
                $display("FAIL hold_drain_ctrl cycle %0d: en/cmen/busy/done=%b, required %b",
                         n, {en, cmen, busy, done}, exp);
            end
            if (n <= 2) begin
                checks++;
                if (rdaddr !== 32'h300) begin
                    errors++;
                    $display("FAIL stride0_addr cycle %0d: rdaddr=%h, required 00000300", n, rdaddr);
                end
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_k1();
        test_k0();
        test_wrap_ignored_start();
        test_reset_mid();
        test_hold_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_issue_seq.md
# systolic_issue_seq

Issue sequencer that sits directly upstream of the 8-lane control skew chain. On a start command it emits one read-enable beat per k-step on `en`, with a strided SRAM address on `rdaddr` and a final-beat marker on `cmen`. It then waits for the skew chain and SRAM read latency to flush before reporting completion. It converts a single tile command into the cycle-accurate lane-0 stimulus that the skew chain replicates diagonally across the PE array.

## Interface
Parameters:
- LANES, 8, number of skew-chain stages to flush after the last beat
- RD_LAT, 1, SRAM read latency in cycles, added to the flush time
- ADDR_W, 32, address width
- LEN_W, 16, width of the k-step count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  ADDR_W  address of beat 0
- stride  in  ADDR_W  address increment per beat
- k_len  in  LEN_W  number of beats to issue
- hold  in  1  back-pressure; pauses issuing while high
- en  out  1  lane-0 read/compute enable, one cycle per beat
- cmen  out  1  lane-0 last-beat marker; high only together with en on the final beat
- rdaddr  out  ADDR_W  lane-0 read address, valid when en=1
- busy  out  1  high from the first ISSUE cycle through the done cycle
- done  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: waiting for a command.
  - ISSUE: emitting beats.
  - DRAIN: flushing the chain.
  - DONE: one cycle.
- IDLE:
  - start=1 with k_len≠0 latches base_addr, stride and k_len, then moves to ISSUE.
  - start=1 with k_len=0 moves straight to DONE; no beat is issued.
  - start=0 stays in IDLE.
- ISSUE:
  - Each cycle with hold=0 emits one beat: en=1 and rdaddr = base_addr + i·stride for beat i = 0..k_len−1.
  - cmen=1 only on beat k_len−1.
  - After the final beat the next state is DRAIN.
  - A cycle with hold=1 emits no beat: en=0, cmen=0, rdaddr retains its last value, and the beat index does not advance.
- DRAIN:
  - Lasts exactly LANES+RD_LAT cycles, counted by a down-counter loaded on the final beat.
  - hold is ignored, because the chain keeps flowing.
  - en=0 and cmen=0 throughout; then the next state is DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- start outside IDLE is ignored, including in the DONE cycle. There is no queuing.
- Address arithmetic is modulo 2^ADDR_W and wraps silently. stride=0 repeats base_addr on every beat.
- k_len=1: the single beat carries en=1 and cmen=1 together.
- All outputs are registered.

## Timing
- Reset: on the cycle after rst=1, state=IDLE, en=0, cmen=0, rdaddr=0, busy=0, done=0, and all counters are cleared.
- rst asserted mid-operation aborts the command. No done pulse is produced.
- Cycle numbering: start is sampled in cycle 0.
- Beat timing:
  - With hold never asserted, the first beat appears in cycle 1 and beat i appears in cycle 1+i.
  - Each held cycle delays every later beat by one cycle.
- Drain: it occupies cycles k_len+1 … k_len+LANES+RD_LAT, with no hold.
- Completion:
  - done is high in cycle k_len+LANES+RD_LAT+1.
  - State is IDLE again in the following cycle, and a start there is accepted.
- busy:
  - It is high from cycle 1 through the done cycle inclusive.
  - When k_len=0, busy and done are both high in cycle 1 only.
- Latency from start to done is k_len + LANES + RD_LAT + 1 + (number of held ISSUE cycles).

## Test plan
- Basic command (defaults): base=0x100, stride=4, k_len=4, hold=0 → en=1 in cycles 1–4 with rdaddr 0x100, 0x104, 0x108, 0x10C; cmen=1 only in cycle 4; done in cycle 14; busy high in cycles 1–14.
- Hold insertion: same command, hold=1 in cycles 2–3 → beats in cycles 1, 4, 5, 6 with addresses 0x100–0x10C; en=0 and rdaddr=0x100 in cycles 2–3; done in cycle 16.
- Edge lengths:
  - k_len=1 → en=1 and cmen=1 together in cycle 1; done in cycle 11.
  - k_len=0 → no en; busy=done=1 in cycle 1 only.
- Wrap and ignored start: base=0xFFFFFFF8, stride=8, k_len=3 → rdaddr 0xFFFFFFF8, 0x0, 0x8. A start pulsed in cycle 2 and another in the done cycle are both ignored; a start the cycle after done is accepted.
- Reset mid-operation: rst in cycle 3 of a k_len=8 command → all outputs 0 from cycle 4 with no done pulse; a new start is accepted after rst is released.
- Hold in drain: hold=1 throughout DRAIN of a k_len=2 command → done still in cycle 12.
